uart_tx_serializer: RTL and testbench



---
 rtl/uart_tx_serializer_if.sv | 22 ++
 rtl/uart_tx_serializer.sv | 94 +++++++++
 tb/tb_uart_tx_serializer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/uart_tx_serializer_if.sv
// Parallel-in handshake and serial-out status bundle for the UART transmitter.
// The master side drives the byte and its framing options; the slave side is the serializer.
interface uart_tx_serializer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  i_data_valid;
  logic [DATA_WIDTH-1:0] i_p_data;
  logic                  i_par_en;
  logic                  i_par_typ;
  logic                  o_tx_out;
  logic                  o_busy;

  modport master (
    output i_data_valid, i_p_data, i_par_en, i_par_typ,
    input  o_tx_out, o_busy
  );

  modport slave (
    input  i_data_valid, i_p_data, i_par_en, i_par_typ,
    output o_tx_out, o_busy
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmitter clocked at the baud rate: start bit, LSB-first data, optional parity, one stop bit.
// A new byte is taken in IDLE or during the stop bit, so frames can run back to back.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input logic                 i_clk,
  input logic                 i_reset,
  uart_tx_serializer_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]            state;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] data_sh;
  logic                  par_en_q;
  logic                  par_bit_q;
  logic                  tx_out;
  logic                  busy;
  logic                  accept;

  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  assign accept = bus.i_data_valid && ((state == IDLE) || (state == STOP));

  // The data register shifts right so the next bit to send is always at index 1.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state     <= IDLE;
      cnt       <= '0;
      data_sh   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_out    <= 1'b1;
      busy      <= 1'b0;
    end else if (accept) begin
      state     <= START;
      data_sh   <= bus.i_p_data;
      par_en_q  <= bus.i_par_en;
      par_bit_q <= parity_bit(bus.i_p_data, bus.i_par_typ);
      tx_out    <= 1'b0;
      busy      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx_out <= 1'b1;
          busy   <= 1'b0;
        end
        START: begin
          state  <= DATA;
          cnt    <= '0;
          tx_out <= data_sh[0];
        end
        DATA: begin
          if (cnt == LAST_BIT) begin
            state  <= par_en_q ? PARITY : STOP;
            tx_out <= par_en_q ? par_bit_q : 1'b1;
          end else begin
            cnt     <= cnt + CNT_W'(1);
            tx_out  <= data_sh[1];
            data_sh <= data_sh >> 1;
          end
        end
        PARITY: begin
          state  <= STOP;
          tx_out <= 1'b1;
        end
        STOP: begin
          state  <= IDLE;
          tx_out <= 1'b1;
          busy   <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          tx_out <= 1'b1;
          busy   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_tx_out = tx_out;
  assign bus.o_busy   = busy;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: a frame-level line model feeds a per-cycle scoreboard,
// alongside directed waveform captures of the reference frames.
module tb_uart_tx_serializer;
  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;
  logic exp_q[$];

  uart_tx_serializer_if #(.DATA_WIDTH(W)) ifc ();

  uart_tx_serializer #(.DATA_WIDTH(W)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference line model: the queue holds the line level for the current cycle onward.
  // A byte is taken only when the frame in flight is down to its final (stop) bit or nothing is in flight.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (ifc.i_data_valid === 1'b1 && exp_q.size() == 0) begin
        exp_q.push_back(1'b0);
        for (int k = 0; k < W; k++) exp_q.push_back(ifc.i_p_data[k]);
        if (ifc.i_par_en)
          exp_q.push_back(((($countones(ifc.i_p_data) + int'(ifc.i_par_typ)) % 2) == 1));
        exp_q.push_back(1'b1);
      end
    end
  end

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      check("line", {31'b0, ifc.o_tx_out}, {31'b0, exp_q[0]});
      check("busy", {31'b0, ifc.o_busy}, 32'd1);
    end else begin
      check("idle_line", {31'b0, ifc.o_tx_out}, 32'd1);
      check("idle_busy", {31'b0, ifc.o_busy}, 32'd0);
    end
  end

  task automatic drive(input logic v, input logic [W-1:0] d, input logic pe, input logic pt);
    ifc.i_data_valid = v;
    ifc.i_p_data     = d;
    ifc.i_par_en     = pe;
    ifc.i_par_typ    = pt;
  endtask

  // Returns just after the accepting edge, with valid already dropped.
  task automatic send_start(input logic [W-1:0] d, input logic pe, input logic pt);
    @(posedge clk); #1 drive(1'b1, d, pe, pt);
    @(posedge clk); #1 ifc.i_data_valid = 1'b0;
  endtask

  task automatic capture(input int n, output logic [31:0] tx_v, output logic [31:0] busy_v);
    tx_v   = '0;
    busy_v = '0;
    repeat (n) begin
      @(negedge clk);
      tx_v   = {tx_v[30:0], ifc.o_tx_out};
      busy_v = {busy_v[30:0], ifc.o_busy};
    end
  endtask

  initial begin
    logic [31:0] tv, bv;
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("reset_line", {31'b0, ifc.o_tx_out}, 32'd1);
    check("reset_busy", {31'b0, ifc.o_busy}, 32'd0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle5", {30'b0, ifc.o_tx_out, ifc.o_busy}, 32'b10);
    end

    send_start(8'hA5, 1'b0, 1'b0);
    capture(11, tv, bv);
    check("a5_tx", tv, 32'b01010010111);
    check("a5_busy", bv, 32'b11111111110);

    send_start(8'hA5, 1'b1, 1'b0);
    capture(12, tv, bv);
    check("a5_even_tx", tv, 32'b010100101011);
    check("a5_even_busy", bv, 32'b111111111110);

    send_start(8'hA5, 1'b1, 1'b1);
    capture(12, tv, bv);
    check("a5_odd_tx", tv, 32'b010100101111);

    send_start(8'h01, 1'b1, 1'b0);
    capture(12, tv, bv);
    check("x01_even_tx", tv, 32'b010000000111);

    @(posedge clk); #1 drive(1'b1, 8'h55, 1'b0, 1'b0);
    @(posedge clk); #1 ifc.i_p_data = 8'h0F;
    fork
      capture(21, tv, bv);
      begin
        repeat (10) @(posedge clk);
        #1 ifc.i_data_valid = 1'b0;
      end
    join
    check("b2b_tx", tv, 32'b010101010101111000011);
    check("b2b_busy", bv, 32'h1FFFFE);

    send_start(8'h3A, 1'b0, 1'b0);
    fork
      capture(11, tv, bv);
      begin
        repeat (4) @(posedge clk);
        #1 drive(1'b1, 8'hFF, 1'b1, 1'b1);
        @(posedge clk);
        #1 drive(1'b0, 8'hFF, 1'b0, 1'b0);
      end
    join
    check("midframe_tx", tv, 32'b00101110011);
    check("midframe_busy", bv, 32'b11111111110);

    send_start(8'h00, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_line", {31'b0, ifc.o_tx_out}, 32'd1);
    check("async_rst_busy", {31'b0, ifc.o_busy}, 32'd0);
    @(negedge clk); #2 rst_n = 1'b1;
    send_start(8'h3C, 1'b0, 1'b0);
    capture(11, tv, bv);
    check("post_rst_tx", tv, 32'b00011110011);
    check("post_rst_busy", bv, 32'b11111111110);

    for (int i = 0; i < 1500; i++) begin
      @(posedge clk);
      #1 drive($urandom_range(0, 3) != 0, W'($urandom), 1'($urandom), 1'($urandom));
    end
    @(posedge clk); #1 drive(1'b0, '0, 1'b0, 1'b0);
    repeat (15) @(posedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
